// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Register-hazard scoreboard for the issue stage. Every in-flight
//   destination register carries a latency countdown. Issue is stalled on
//   RAW (a source is not yet available) and WAW (the destination is still
//   pending) hazards.
//
// Optional feature macro: SCOREBOARD_FORWARD_EN
//   defined   : a source whose count is 1 is ready and reported on rs_fwd
//   undefined : a source is ready only at count 0, and rs_fwd is tied low
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset; clears every entry
//   flush        in   synchronous clear of all pending entries
//   issue_valid  in   instruction presented for issue
//   issue_rd_we  in   instruction writes a destination register
//   issue_rd     in   destination register
//   issue_lat    in   cycles until writeback (0 -> 1, above MAX_LAT -> MAX_LAT)
//   rs_valid     in   per-port source-in-use flags
//   rs_addr      in   packed source addresses, port i at [i*AW +: AW]
//   stall        out  issue blocked this cycle (combinational)
//   issue_accept out  issue_valid && !stall && !flush
//   rs_fwd       out  per-port "take operand from bypass"
//   busy_vec     out  pending mask derived from registered counts
//   busy_count   out  population count of busy_vec
module hazard_scoreboard #(
    parameter int NUM_REGS   = 32,
    parameter int READ_PORTS = 2,
    parameter int MAX_LAT    = 4,
    parameter int AW         = $clog2(NUM_REGS),
    parameter int LW         = $clog2(MAX_LAT + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             issue_valid,
    input  logic                             issue_rd_we,
    input  logic [AW-1:0]                    issue_rd,
    input  logic [LW-1:0]                    issue_lat,
    input  logic [READ_PORTS-1:0]            rs_valid,
    input  logic [READ_PORTS*AW-1:0]         rs_addr,
    output logic                             stall,
    output logic                             issue_accept,
    output logic [READ_PORTS-1:0]            rs_fwd,
    output logic [NUM_REGS-1:0]              busy_vec,
    output logic [$clog2(NUM_REGS+1)-1:0]    busy_count
);

    localparam int CW = $clog2(NUM_REGS + 1);

    logic [LW-1:0] count_q [NUM_REGS];
    logic [LW-1:0] count_d [NUM_REGS];
    logic [LW-1:0] lat_norm;
    logic          raw;
    logic          waw;
    logic [AW-1:0] src;
    logic [LW-1:0] src_cnt;

    // Latency normalisation: 0 behaves as 1, oversize saturates.
    always_comb begin
        if (issue_lat == '0) begin
            lat_norm = LW'(1);
        end else if (int'(issue_lat) > MAX_LAT) begin
            lat_norm = LW'(MAX_LAT);
        end else begin
            lat_norm = issue_lat;
        end
    end

    // Source readiness. count_q[0] is always 0, so x0 never stalls and
    // never forwards.
    always_comb begin
        raw     = 1'b0;
        rs_fwd  = '0;
        src     = '0;
        src_cnt = '0;
        for (int unsigned i = 0; i < READ_PORTS; i++) begin
            src     = rs_addr[i*AW +: AW];
            src_cnt = count_q[src];
`ifdef SCOREBOARD_FORWARD_EN
            // A result landing at the coming edge is on the bypass network.
            if (rs_valid[i] && (src != '0) && (src_cnt == LW'(1))) begin
                rs_fwd[i] = 1'b1;
            end
            if (rs_valid[i] && (src_cnt > LW'(1))) begin
                raw = 1'b1;
            end
`else
            if (rs_valid[i] && (src_cnt != '0)) begin
                raw = 1'b1;
            end
`endif
        end
    end

    assign waw          = issue_rd_we && (issue_rd != '0) && (count_q[issue_rd] != '0);
    assign stall        = issue_valid && (raw || waw);
    assign issue_accept = issue_valid && !stall && !flush;

    // Per-register update: flush, then allocation, then countdown.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            count_d[r] = count_q[r];
            if (r == 0) begin
                count_d[r] = '0;
            end else if (flush) begin
                count_d[r] = '0;
            end else if (issue_accept && issue_rd_we && (issue_rd == AW'(r))) begin
                count_d[r] = lat_norm;
            end else if (count_q[r] != '0) begin
                count_d[r] = count_q[r] - LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                count_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                count_q[r] <= count_d[r];
            end
        end
    end

    always_comb begin
        busy_vec   = '0;
        busy_count = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (count_q[r] != '0) begin
                busy_vec[r] = 1'b1;
                busy_count  = busy_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int NR = 32;
    localparam int RP = 2;
    localparam int ML = 4;
    localparam int AW = 5;
    localparam int LW = 3;
    localparam int BW = 6;
`ifdef SCOREBOARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              issue_valid;
    logic              issue_rd_we;
    logic [AW-1:0]     issue_rd;
    logic [LW-1:0]     issue_lat;
    logic [RP-1:0]     rs_valid;
    logic [RP*AW-1:0]  rs_addr;
    logic              stall;
    logic              issue_accept;
    logic [RP-1:0]     rs_fwd;
    logic [NR-1:0]     busy_vec;
    logic [BW-1:0]     busy_count;

    hazard_scoreboard #(
        .NUM_REGS   (NR),
        .READ_PORTS (RP),
        .MAX_LAT    (ML)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_rd_we  (issue_rd_we),
        .issue_rd     (issue_rd),
        .issue_lat    (issue_lat),
        .rs_valid     (rs_valid),
        .rs_addr      (rs_addr),
        .stall        (stall),
        .issue_accept (issue_accept),
        .rs_fwd       (rs_fwd),
        .busy_vec     (busy_vec),
        .busy_count   (busy_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          stall;
        logic          acc;
        logic [RP-1:0] fwd;
        logic [NR-1:0] busy;
        logic [BW-1:0] bcnt;
    } exp_t;

    exp_t          exp_q[$];
    int            mcnt[NR];
    int            tests = 0;
    int            fails = 0;
    logic          obs_stall;
    logic          obs_acc;
    logic [RP-1:0] obs_fwd;
    logic [NR-1:0] obs_busy;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int norm_lat(input int l);
        if (l == 0) return 1;
        if (l > ML) return ML;
        return l;
    endfunction

    function automatic bit src_ready(input int r);
        return (r == 0) || (mcnt[r] == 0) || (FWD && mcnt[r] == 1);
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NR; r++) mcnt[r] = 0;
    endtask

    // One issue cycle: drive at posedge+1, predict, compare at negedge,
    // advance the model at the following posedge.
    task automatic drive(input bit v, input bit we, input int rd, input int lat,
                         input bit rv0, input int a0, input bit rv1, input int a1,
                         input bit fl);
        exp_t e;
        exp_t got;
        int   bc;
        bit   raw;
        bit   waw;
        issue_valid = v;
        issue_rd_we = we;
        issue_rd    = AW'(rd);
        issue_lat   = LW'(lat);
        rs_valid    = {rv1, rv0};
        rs_addr     = {AW'(a1), AW'(a0)};
        flush       = fl;
        e  = '0;
        bc = 0;
        for (int r = 0; r < NR; r++) begin
            if (mcnt[r] != 0) begin
                e.busy[r] = 1'b1;
                bc++;
            end
        end
        e.bcnt   = BW'(bc);
        raw      = (rv0 && !src_ready(a0)) || (rv1 && !src_ready(a1));
        waw      = we && (rd != 0) && (mcnt[rd] != 0);
        e.stall  = v && (raw || waw);
        e.acc    = v && !e.stall && !fl;
        e.fwd[0] = FWD && rv0 && (a0 != 0) && (mcnt[a0] == 1);
        e.fwd[1] = FWD && rv1 && (a1 != 0) && (mcnt[a1] == 1);
        exp_q.push_back(e);
        @(negedge clk);
        obs_stall = stall;
        obs_acc   = issue_accept;
        obs_fwd   = rs_fwd;
        obs_busy  = busy_vec;
        if (exp_q.size() == 0) begin
            check("queue_empty", 64'd1, 64'd0);
        end else begin
            got = exp_q.pop_front();
            check("stall",        64'(stall),        64'(got.stall));
            check("issue_accept", 64'(issue_accept), 64'(got.acc));
            check("rs_fwd",       64'(rs_fwd),       64'(got.fwd));
            check("busy_vec",     64'(busy_vec),     64'(got.busy));
            check("busy_count",   64'(busy_count),   64'(got.bcnt));
        end
        @(posedge clk);
        for (int r = 1; r < NR; r++) begin
            if (fl) mcnt[r] = 0;
            else if (e.acc && we && rd == r) mcnt[r] = norm_lat(lat);
            else if (mcnt[r] != 0) mcnt[r] = mcnt[r] - 1;
        end
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        flush = 1'b0;
        issue_valid = 1'b0;
        issue_rd_we = 1'b0;
        issue_rd = '0;
        issue_lat = '0;
        rs_valid = '0;
        rs_addr = '0;
        model_clear();
        #2;
        check("reset_busy_vec",   64'(busy_vec),     64'd0);
        check("reset_busy_count", 64'(busy_count),   64'd0);
        check("reset_stall",      64'(stall),        64'd0);
        check("reset_accept",     64'(issue_accept), 64'd0);
        check("reset_fwd",        64'(rs_fwd),       64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) idle();

        // RAW on a latency-3 producer
        drive(1, 1, 1, 3, 0, 0, 0, 0, 0);
        n = 0;
        do begin
            drive(1, 0, 0, 1, 1, 1, 0, 0, 0);
            if (obs_stall) n++;
        end while (obs_stall && n < 10);
        check("raw_l3_stall_cycles", 64'(n), FWD ? 64'd2 : 64'd3);
        check("raw_l3_fwd_at_accept", 64'(obs_fwd[0]), 64'(FWD));
        repeat (3) idle();

        // Back-to-back dependent on an L=1 producer via port 1
        drive(1, 1, 3, 1, 0, 0, 0, 0, 0);
        n = 0;
        do begin
            drive(1, 0, 0, 1, 0, 0, 1, 3, 0);
            if (obs_stall) n++;
        end while (obs_stall && n < 10);
        check("raw_l1_stall_cycles", 64'(n), FWD ? 64'd0 : 64'd1);
        check("raw_l1_fwd_port1", 64'(obs_fwd[1]), 64'(FWD));
        idle();

        // WAW: second write to x5 waits for the first to drain
        drive(1, 1, 5, 4, 0, 0, 0, 0, 0);
        n = 0;
        do begin
            drive(1, 1, 5, 1, 0, 0, 0, 0, 0);
            if (obs_stall) n++;
        end while (obs_stall && n < 10);
        check("waw_stall_cycles", 64'(n), 64'd4);
        idle();
        check("waw_realloc_busy5", 64'(obs_busy[5]), 64'd1);
        idle();
        check("waw_realloc_cleared", 64'(obs_busy[5]), 64'd0);

        // x0 never allocates and never hazards
        drive(1, 1, 0, 4, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 1, 0, 1, 0, 0);
        check("x0_no_stall", 64'(obs_stall), 64'd0);
        check("x0_no_busy", 64'(obs_busy), 64'd0);

        // Flush overrides a same-cycle issue
        drive(1, 1, 2, 4, 0, 0, 0, 0, 0);
        drive(1, 1, 4, 4, 0, 0, 0, 0, 0);
        drive(1, 1, 6, 4, 0, 0, 0, 0, 0);
        drive(1, 1, 7, 4, 0, 0, 0, 0, 1);
        check("flush_accept_low", 64'(obs_acc), 64'd0);
        idle();
        check("flush_cleared", 64'(obs_busy), 64'd0);

        // Latency normalisation
        drive(1, 1, 8, 0, 0, 0, 0, 0, 0);
        n = 0;
        repeat (6) begin
            idle();
            if (obs_busy[8]) n++;
        end
        check("lat0_busy_cycles", 64'(n), 64'd1);
        drive(1, 1, 9, 7, 0, 0, 0, 0, 0);
        n = 0;
        repeat (8) begin
            idle();
            if (obs_busy[9]) n++;
        end
        check("lat7_busy_cycles", 64'(n), 64'd4);

        // Asynchronous reset mid-run with three pending registers
        drive(1, 1, 10, 4, 0, 0, 0, 0, 0);
        drive(1, 1, 11, 4, 0, 0, 0, 0, 0);
        drive(1, 1, 12, 4, 0, 0, 0, 0, 0);
        issue_valid = 1'b0;
        rs_valid = '0;
        #1;
        check("pre_rst_busy_count", 64'(busy_count), 64'd3);
        rst = 1'b0;
        #1;
        check("mid_rst_busy_vec",   64'(busy_vec),   64'd0);
        check("mid_rst_busy_count", 64'(busy_count), 64'd0);
        check("mid_rst_stall",      64'(stall),      64'd0);
        #1;
        rst = 1'b1;
        model_clear();
        drive(1, 0, 0, 1, 1, 10, 1, 11, 0);

        // Randomised traffic on a small register window
        repeat (300) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 7), ($urandom_range(0, 15) == 0));
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised register-hazard scoreboard for the pipelined CPU's issue stage.
- Tracks every in-flight destination register with a per-register latency countdown.
- Raises `stall` on RAW (source not yet available) and WAW (destination still pending) hazards.
- Optionally tells the datapath when an operand must come from the bypass network. Generalises the fixed 5-stage hazard handling to N read ports and variable-latency functional units.

Parameters:
- NUM_REGS, 32, architectural registers; register 0 is hardwired zero and never busy
- READ_PORTS, 2, source operands checked per issue
- MAX_LAT, 4, maximum issue-to-result latency in cycles (>=1)
- AW, $clog2(NUM_REGS), register address width (derived)
- LW, $clog2(MAX_LAT+1), latency field width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all pending entries (branch mispredict/trap)
- issue_valid  in  1  instruction presented for issue this cycle
- issue_rd_we  in  1  instruction writes a destination register
- issue_rd  in  AW  destination register
- issue_lat  in  LW  cycles until result is written back
- rs_valid  in  READ_PORTS  per-port source-in-use flag
- rs_addr  in  READ_PORTS*AW  packed source addresses, port i at [i*AW +: AW]
- stall  out  1  issue blocked this cycle (combinational)
- issue_accept  out  1  issue_valid && !stall && !flush (combinational)
- rs_fwd  out  READ_PORTS  per-port "take operand from bypass" (combinational)
- busy_vec  out  NUM_REGS  registered pending mask, bit r = count[r]!=0
- busy_count  out  $clog2(NUM_REGS+1)  population count of busy_vec (combinational from state)

Behaviour:
- State: `count[r]` (LW bits) per register r=1..NUM_REGS-1. `count[0]` is constant 0.
- Reset (rst low, asynchronous): all counts are 0.
  - With no issue_valid, all outputs are 0: busy_vec=0, busy_count=0, stall=0, rs_fwd=0, issue_accept=0.
- Latency normalisation: issue_lat=0 is treated as 1; issue_lat>MAX_LAT saturates to MAX_LAT. Call the result L.
- Source readiness for port i, with r=rs_addr[i]:
  - ready when count[r]==0.
  - With forwarding enabled (see Optional Feature), also ready when count[r]==1.
  - r=0 is always ready.
- stall = issue_valid && (RAW || WAW):
  - RAW: some port i has rs_valid[i] and is not ready.
  - WAW: issue_rd_we && issue_rd!=0 && count[issue_rd]!=0.
- Per-register update at each rising edge, in this priority order:
  1. flush=1 -> every count becomes 0. flush overrides a same-cycle issue; issue_accept=0.
  2. issue_accept && issue_rd_we && issue_rd==r && r!=0 -> count[r] = L.
  3. count[r]!=0 -> count[r] decrements by 1.
  4. otherwise count[r] holds.
- Timing: an issue accepted at edge T with latency L makes busy_vec[rd]=1 from T through T+L-1, cleared at edge T+L.
  - Without forwarding, a dependent instruction issues no earlier than the cycle after edge T+L.
- Simultaneous events:
  - Issue to a register whose count is 1 this cycle is a WAW stall; it retries next cycle.
  - A RAW check and a decrement in the same cycle both use the pre-edge count.
- Writes to x0 never allocate. Sources reading x0 never stall and never assert rs_fwd.
- rs_fwd[i] = rs_valid[i] && rs_addr[i]!=0 && count[rs_addr[i]]==1. It is asserted even while stall=1 because of another port.
- rst asserted mid-operation clears every pending entry immediately. No partial state survives.

Optional Feature:
- Macro: SCOREBOARD_FORWARD_EN.
- Defined: a source with count==1 is ready, and rs_fwd reports it. Back-to-back dependent ALU ops (L=1) therefore issue without stalling.
- Undefined: readiness requires count==0. rs_fwd is tied to 0, and no forwarding logic is synthesised.

Test Plan:
- Reset then idle, no issue_valid -> busy_vec=0, busy_count=0, stall=0 for 5 cycles. Assert rst mid-run with 3 busy registers -> all cleared before the next edge.
- Issue rd=1, L=3 at edge T; next instruction reads rs0=1 -> without macro: stall=1 for 3 cycles, accept in the cycle after edge T+3. With macro: stall=1 for 2 cycles, then accept with rs_fwd[0]=1.
- Issue rd=3, L=1; dependent reads rs1=3 next cycle -> macro defined: stall=0, rs_fwd[1]=1. Undefined: exactly one stall cycle.
- WAW: rd=5, L=4 pending; issue rd=5, L=1 -> stall until count[5]==0, then busy_vec[5] is set again with count=1.
- Issue rd=0, L=4, then read rs0=0 -> no allocation, busy_count=0, stall=0, rs_fwd=0.
- Rd 2/4/6 pending with L=4, assert flush with issue_valid for rd=7 -> next cycle busy_vec=0, issue_accept was 0, rd=7 not allocated. Issue_lat=0 then gives count=1; issue_lat=7 (MAX_LAT=4) gives count=4.
